// File: rtl/pipeline_controller_if.sv
// Control/status bundle between pipeline_controller (master) and the core datapath (slave).
interface pipeline_controller_if #(
  parameter int unsigned SEL_PC_WIDTH = 2
);
  logic                    memory_done;
  logic [SEL_PC_WIDTH-1:0] pc_sel;
  logic                    br_taken;
  logic [31:0]             ir;
  logic [31:0]             next_pc;
  logic                    c_fetch_stall;
  logic [SEL_PC_WIDTH-1:0] c_pc_sel;
  logic                    c_br_taken;
  logic [31:0]             c_next_pc;
  logic                    halted;
  logic                    mem_timeout;

  modport master (
    input  memory_done, pc_sel, br_taken, ir, next_pc,
    output c_fetch_stall, c_pc_sel, c_br_taken, c_next_pc, halted, mem_timeout
  );

  modport slave (
    output memory_done, pc_sel, br_taken, ir, next_pc,
    input  c_fetch_stall, c_pc_sel, c_br_taken, c_next_pc, halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_controller.sv
// Pipeline control FSM: memory-op fetch stalls, one-cycle PC redirect with wrong-path flush,
// and sticky halt on SYSTEM opcodes, memory timeout or misaligned redirect targets.
module pipeline_controller #(
  parameter int unsigned SEL_PC_WIDTH  = 2,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_controller_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_WIDTH > 4) ? TIMEOUT_WIDTH : 4;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_RUN,
    ST_MEM_WAIT,
    ST_FLUSH,
    ST_HALT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    stall_q, stall_d;
  logic [SEL_PC_WIDTH-1:0] sel_q, sel_d;
  logic                    br_q, br_d;
  logic [31:0]             npc_q, npc_d;
  logic                    halted_q, halted_d;
  logic                    tmo_q, tmo_d;

  logic redirect_c;
  logic misaligned_c;
  logic system_c;
  logic memop_c;
  logic unused_ir;

  // Decode of the executing instruction's status
  assign redirect_c   = (bus.pc_sel == SEL_PC_WIDTH'(2)) || (bus.pc_sel == SEL_PC_WIDTH'(3)) ||
                        ((bus.pc_sel == SEL_PC_WIDTH'(1)) && bus.br_taken);
  assign misaligned_c = (bus.next_pc[1:0] != 2'b00);
  assign system_c     = (bus.ir[6:0] == OP_SYSTEM);
  assign memop_c      = (bus.ir[6:0] == OP_LOAD) || (bus.ir[6:0] == OP_STORE);
  assign unused_ir    = ^bus.ir[31:7];

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    sel_d    = '0;
    br_d     = 1'b0;
    npc_d    = npc_q;
    halted_d = halted_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_RUN;
        stall_d = 1'b0;
      end
      ST_RUN: begin
        stall_d = 1'b0;
        if (redirect_c) begin
          if (misaligned_c) begin
            state_d  = ST_HALT;
            stall_d  = 1'b1;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
            sel_d   = bus.pc_sel;
            br_d    = 1'b1;
            npc_d   = bus.next_pc;
          end
        end else if (system_c) begin
          state_d  = ST_HALT;
          stall_d  = 1'b1;
          halted_d = 1'b1;
        end else if (memop_c) begin
          // a memory_done seen here completes an older op and is not consumed
          state_d = ST_MEM_WAIT;
          stall_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        stall_d = 1'b1;
        if (bus.memory_done) begin
          state_d = ST_RUN;
          stall_d = 1'b0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // strobe cycle plus FLUSH_CYCLES bubbles, all with decode ignored
        stall_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        stall_d  = 1'b1;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RESET;
        stall_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      stall_q  <= 1'b1;
      sel_q    <= '0;
      br_q     <= 1'b0;
      npc_q    <= '0;
      halted_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      sel_q    <= sel_d;
      br_q     <= br_d;
      npc_q    <= npc_d;
      halted_q <= halted_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.c_fetch_stall = stall_q;
  assign bus.c_pc_sel      = sel_q;
  assign bus.c_br_taken    = br_q;
  assign bus.c_next_pc     = npc_q;
  assign bus.halted        = halted_q;
  assign bus.mem_timeout   = tmo_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LW    = 32'h0000_2083;
  localparam logic [31:0] LD0   = 32'h0000_0003;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pipeline_controller_if #(.SEL_PC_WIDTH(2)) bus ();

  pipeline_controller #(
    .SEL_PC_WIDTH(2), .FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic stall, input logic [1:0] sel,
                         input logic br, input logic [31:0] npc, input logic hlt, input logic tmo);
    chk({tag, ".stall"},  32'(bus.c_fetch_stall), 32'(stall));
    chk({tag, ".pc_sel"}, 32'(bus.c_pc_sel),      32'(sel));
    chk({tag, ".br"},     32'(bus.c_br_taken),    32'(br));
    chk({tag, ".npc"},    bus.c_next_pc,          npc);
    chk({tag, ".halted"}, 32'(bus.halted),        32'(hlt));
    chk({tag, ".tmo"},    32'(bus.mem_timeout),   32'(tmo));
  endtask

  task automatic drive(input logic [31:0] ir, input logic [1:0] sel, input logic br,
                       input logic [31:0] npc, input logic done);
    bus.ir          = ir;
    bus.pc_sel      = sel;
    bus.br_taken    = br;
    bus.next_pc     = npc;
    bus.memory_done = done;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);

    // Reset release
    repeat (10) step();
    chk_all("reset", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("reset_release_hold.stall", 32'(bus.c_fetch_stall), 32'd1);
    step();
    chk_all("run_entry", 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Taken branch: one-cycle strobe, then 2 ignored decode cycles
    drive(NOP, 2'd1, 1'b1, 32'h0000_0040, 1'b0);
    step();
    chk_all("br_strobe", 1'b0, 2'd1, 1'b1, 32'h40, 1'b0, 1'b0);
    drive(LD0, 2'd1, 1'b1, 32'h0000_0080, 1'b0);
    step();
    chk_all("flush1", 1'b0, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);
    step();
    chk_all("flush2", 1'b0, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);
    step();
    chk_all("flush3", 1'b0, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);
    drive(LD0, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk("post_flush_load.stall", 32'(bus.c_fetch_stall), 32'd1);
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b1);
    step();
    chk("post_flush_done.stall", 32'(bus.c_fetch_stall), 32'd0);

    // Not-taken branch
    drive(NOP, 2'd1, 1'b0, 32'h0000_0100, 1'b0);
    step();
    chk_all("not_taken", 1'b0, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);

    // Load wait with a stale done in the entry cycle
    drive(LW, 2'd0, 1'b0, 32'h0, 1'b1);
    step();
    chk("lw_entry.stall", 32'(bus.c_fetch_stall), 32'd1);
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk("lw_stale_done_ignored.stall", 32'(bus.c_fetch_stall), 32'd1);
    repeat (3) step();
    chk_all("lw_wait4", 1'b1, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);
    bus.memory_done = 1'b1;
    step();
    bus.memory_done = 1'b0;
    chk_all("lw_done", 1'b0, 2'd0, 1'b0, 32'h40, 1'b0, 1'b0);

    // Redirect and load together: redirect wins
    drive(LW, 2'd2, 1'b0, 32'h0000_0200, 1'b0);
    step();
    chk_all("jmp_over_load", 1'b0, 2'd2, 1'b0 | 1'b1, 32'h200, 1'b0, 1'b0);
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    chk_all("jmp_flush_done", 1'b0, 2'd0, 1'b0, 32'h200, 1'b0, 1'b0);

    // ECALL halts; sticky against later redirects
    drive(ECALL, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("ecall", 1'b1, 2'd0, 1'b0, 32'h200, 1'b1, 1'b0);
    drive(NOP, 2'd2, 1'b0, 32'h0000_0300, 1'b0);
    repeat (2) step();
    chk_all("halt_sticky", 1'b1, 2'd0, 1'b0, 32'h200, 1'b1, 1'b0);

    rst = 1'b1;
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("reset2", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Misaligned redirect target
    drive(NOP, 2'd2, 1'b0, 32'h0000_0042, 1'b0);
    step();
    chk_all("misaligned", 1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("misaligned_no_strobe.br", 32'(bus.c_br_taken), 32'd0);

    rst = 1'b1;
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Reset in the middle of MEM_WAIT
    drive(LW, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_all("rst_mid_wait", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("rst_mid_wait_release.stall", 32'(bus.c_fetch_stall), 32'd0);

    // Done on the final allowed wait cycle wins over timeout
    drive(LW, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (254) step();
    chk_all("wait254", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.memory_done = 1'b1;
    step();
    bus.memory_done = 1'b0;
    chk_all("done_at_limit", 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Timeout after 255 wait cycles
    drive(LW, 2'd0, 1'b0, 32'h0, 1'b0);
    step();
    drive(NOP, 2'd0, 1'b0, 32'h0, 1'b0);
    repeat (254) step();
    chk_all("tmo_pre", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_all("tmo_hit", 1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    bus.memory_done = 1'b1;
    repeat (3) step();
    bus.memory_done = 1'b0;
    chk_all("tmo_sticky", 1'b1, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    chk_all("tmo_reset", 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("tmo_reset_run.stall", 32'(bus.c_fetch_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
